jtag_host: RTL and testbench
============================

// Module: jtag_host
// PURPOSE
// - JTAG initiator (probe side): drives tck/tms/tdi and samples tdo of an external or on-chip TAP.
// - Turns simple commands (TAP reset, IR shift, DR shift, idle clocks) into TMS/TDI sequences.
// - Tracks the target TAP state internally and returns the captured TDO bits.
// - Used as the bench/host counterpart of our TAP controller, e.g. to read the 32-bit IDCODE.
// PARAMETERS
// - CLK_DIV  2   tck half-period in clk cycles (>=1); tck period = 2*CLK_DIV clk
// - MAX_LEN  32  max bits per shift; width of cmd_data/rsp_data
// PORTS
// - clk          in   1        system clock; all logic on posedge
// - reset        in   1        synchronous, active-high
// - cmd_valid    in   1        command offered
// - cmd_ready    out  1        command accepted when cmd_valid & cmd_ready
// - cmd_op       in   2        00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE
// - cmd_len      in   6        bit count (shifts) / tck count (IDLE)
// - cmd_data     in   MAX_LEN  TDI bits, LSB shifted first
// - rsp_valid    out  1        one-clk completion pulse
// - rsp_err      out  1        qualifies rsp_valid: command rejected
// - rsp_data     out  MAX_LEN  TDO bits, bit i = i-th sampled bit; bits >= len are 0
// - busy         out  1        command in progress
// - jtag_tck     out  1        JTAG clock, idles low
// - jtag_tms     out  1        TMS
// - jtag_tdi     out  1        TDI
// - jtag_tdo     in   1        TDO from target
// - jtag_trst_n  out  1        TAP reset, active-low
// BEHAVIOUR
// - Reset values: cmd_ready=0 during reset, 1 the cycle after release; rsp_valid=0, rsp_err=0,
//   rsp_data=0, busy=0, jtag_tck=0, jtag_tms=1, jtag_tdi=0, jtag_trst_n=0 while reset, 1 after.
// - Tick = one tck period: CLK_DIV clk low, then CLK_DIV clk high. tms/tdi change only on the
//   tck falling edge (low-phase start); jtag_tdo is registered on the clk edge where tck rises.
// - FSM: READY -> (accept) RUN -> DONE -> READY. cmd_ready=1 only in READY; busy=1 in RUN/DONE.
// - TAP_RESET: 5 ticks TMS=1 then 1 tick TMS=0 -> Run-Test/Idle; sets internal synced flag.
// - SHIFT_DR n: TMS 1,0,0 (SelDR,CapDR,ShDR), n ticks TDI=cmd_data[i], TMS=0 except last bit TMS=1
//   (Exit1), then TMS 1,0 (Update,RTI). n+5 ticks. TDO sampled only on the n data ticks.
// - SHIFT_IR n: as DR with TMS 1,1,0,0 prefix. n+6 ticks. tdi=0 on non-data ticks.
// - IDLE n: n ticks TMS=0 in RTI; n=0 completes without ticks. rsp_data=0.
// - Completion: rsp_valid pulses on the clk after the final tick's high phase (tck back low);
//   cmd_ready=1 in that same cycle, so back-to-back commands lose no clk cycle.
// - Rejection (rsp_valid & rsp_err, no tck activity, 1 clk after accept): SHIFT_* with len 0
//   or len > MAX_LEN; SHIFT_* while synced=0. synced cleared by reset.
// - cmd_data/op/len latched at accept; input changes afterwards are ignored.
// - rsp_valid has no backpressure; rsp_data/rsp_err hold until next accept.
// - Reset mid-command: next clk tck=0, tms=1, busy=0, command dropped, no rsp_valid, synced=0.
// CONFIGURATION
// - JTAG_HOST_TRST_EN defined: TAP_RESET first drives jtag_trst_n=0 for 2 ticks (tck toggling,
//   TMS=1), then the 6-tick TMS sequence (8 ticks total).
// - Not defined: jtag_trst_n constant 1 after reset release; TAP_RESET is TMS-only (6 ticks).
// TESTING (CLK_DIV=2, MAX_LEN=32, bench TAP model with IDCODE 0x000FAF01)
// - Release reset, TAP_RESET, macro off -> TMS 1,1,1,1,1,0 over 24 clk, rsp_valid, rsp_err=0.
// - Macro on, TAP_RESET -> jtag_trst_n=0 for 8 clk, then same TMS; done at 32 clk.
// - SHIFT_IR len 4 data 4'b1110 -> TMS 1,1,0,0,0,0,0,1,1,0; TDI data bits 0,1,1,1; 10 ticks.
// - SHIFT_DR len 32 data 0 after IDCODE IR -> rsp_data=32'h000FAF01, rsp_err=0, 37 ticks.
// - SHIFT_DR before any TAP_RESET, and len 0 / len 33 -> rsp_err=1, jtag_tck stays 0.
// - Reset at DR bit 10 -> tck=0, tms=1, busy=0, no rsp; next SHIFT_DR rejected until TAP_RESET.

Source files
------------

// File: rtl/jtag_host.sv
// JTAG probe-side initiator: turns TAP_RESET / SHIFT_IR / SHIFT_DR / IDLE commands into tck/tms/tdi ticks.
// Optional macro JTAG_HOST_TRST_EN: TAP_RESET first pulses jtag_trst_n low for 2 ticks.
module jtag_host #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo,
    output logic               jtag_trst_n
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = 7;
`ifdef JTAG_HOST_TRST_EN
    localparam int TRST_TICKS = 2;
`else
    localparam int TRST_TICKS = 0;
`endif

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    typedef enum logic [1:0] {ST_READY, ST_RUN, ST_DONE} state_t;

    typedef struct packed {
        logic             trst_n;
        logic             tms;
        logic             data;
        logic [IDX_W-1:0] idx;
    } tick_t;

    function automatic int total_ticks(input logic [1:0] op, input logic [5:0] len);
        case (op)
            OP_RESET: return TRST_TICKS + 6;
            OP_IR:    return int'(len) + 6;
            OP_DR:    return int'(len) + 5;
            default:  return int'(len);
        endcase
    endfunction

    // Pin values for tick k of a command: prefix walks RTI to Shift, data ticks, then Exit1/Update/RTI.
    function automatic tick_t tick_info(input logic [1:0] op, input logic [5:0] len, input int k);
        tick_t t;
        int    li;
        int    pre;
        int    bi;
        t.trst_n = 1'b1;
        t.tms    = 1'b0;
        t.data   = 1'b0;
        t.idx    = '0;
        li       = int'(len);
        pre      = (op == OP_IR) ? 4 : 3;
        bi       = k - pre;
        case (op)
            OP_RESET: begin
                t.trst_n = !(k < TRST_TICKS);
                t.tms    = (k < TRST_TICKS + 5);
            end
            OP_IDLE: begin
                t.tms = 1'b0;
            end
            default: begin
                if (k < pre) begin
                    t.tms = (op == OP_IR) ? (k < 2) : (k == 0);
                end else if (k < pre + li) begin
                    t.data = 1'b1;
                    t.idx  = IDX_W'(bi);
                    t.tms  = (bi == li - 1);
                end else begin
                    t.tms = (k == pre + li);
                end
            end
        endcase
        return t;
    endfunction

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trst_n_q, trst_n_d;
    logic               synced_q, synced_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [1:0]         op_q, op_d;
    logic [5:0]         len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;

    tick_t cur, nxt, first;
    logic  last_tick;
    logic  reject;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_n_d    = (state_q == ST_READY) ? 1'b1 : trst_n_q;
        synced_d    = synced_q;
        div_d       = div_q;
        tick_d      = tick_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;

        cur       = tick_info(op_q, len_q, int'(tick_q));
        nxt       = tick_info(op_q, len_q, int'(tick_q) + 1);
        first     = tick_info(cmd_op, cmd_len, 0);
        last_tick = (int'(tick_q) == total_ticks(op_q, len_q) - 1);
        reject    = ((cmd_op == OP_IR) || (cmd_op == OP_DR)) &&
                    ((cmd_len == 6'd0) || (int'(cmd_len) > MAX_LEN) || !synced_q);

        case (state_q)
            ST_READY: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d       = cmd_op;
                    len_d      = cmd_len;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    div_d      = '0;
                    tick_d     = '0;
                    if (reject) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (total_ticks(cmd_op, cmd_len) == 0) begin
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        tck_d    = 1'b0;
                        tms_d    = first.tms;
                        tdi_d    = first.data ? cmd_data[first.idx] : 1'b0;
                        trst_n_d = first.trst_n;
                    end
                end
            end
            default: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!tck_q) begin
                        // Rising edge of tck: TDO has been stable since the previous falling edge.
                        tck_d = 1'b1;
                        if (cur.data) begin
                            rsp_data_d[cur.idx] = jtag_tdo;
                        end
                        if (last_tick) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        tck_d = 1'b0;
                        if (last_tick) begin
                            state_d     = ST_READY;
                            rsp_valid_d = 1'b1;
                            tdi_d       = 1'b0;
                            if (op_q == OP_RESET) begin
                                synced_d = 1'b1;
                            end
                        end else begin
                            tick_d   = tick_q + 1'b1;
                            tms_d    = nxt.tms;
                            tdi_d    = nxt.data ? data_q[nxt.idx] : 1'b0;
                            trst_n_d = nxt.trst_n;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase

        cmd_ready_d = (state_d == ST_READY);
        busy_d      = (state_d != ST_READY);
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        len_q  <= len_d;
        data_q <= data_d;
        if (reset) begin
            state_q     <= ST_READY;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_n_q    <= 1'b0;
            synced_q    <= 1'b0;
            div_q       <= '0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_n_q    <= trst_n_d;
            synced_q    <= synced_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign jtag_tck    = tck_q;
    assign jtag_tms    = tms_q;
    assign jtag_tdi    = tdi_q;
    assign jtag_trst_n = trst_n_q;

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: drives random commands into the host, which talks to a behavioural TAP
// holding IDCODE 0x000FAF01; results are compared against a bit-stream model of the scan chains.
module tb_jtag_host;

    localparam int CDIV = 2;
    localparam int MLEN = 32;
    localparam logic [31:0] IDCODE = 32'h000FAF01;
    localparam logic [3:0]  IDC_IR = 4'b1110;
`ifdef JTAG_HOST_TRST_EN
    localparam int TRST_T = 2;
`else
    localparam int TRST_T = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = 2'b00;
    logic [5:0]      cmd_len = 6'd0;
    logic [MLEN-1:0] cmd_data = '0;
    logic            rsp_valid, rsp_err, busy;
    logic [MLEN-1:0] rsp_data;
    logic            jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
    logic            tdo_r = 1'b0;

    always #5 clk = ~clk;

    jtag_host #(.CLK_DIV(CDIV), .MAX_LEN(MLEN)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(tdo_r), .jtag_trst_n(jtag_trst_n)
    );

    // Target TAP: standard 16-state controller, IR 4 bits, IDCODE or 1-bit BYPASS on DR.
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t        tap_st = TLR;
    logic [3:0]  tap_ir = IDC_IR;
    logic [3:0]  ir_sr = 4'b0;
    logic [31:0] dr_sr = 32'b0;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDR  : PADR;
            PADR:  return tms ? EX2DR : PADR;
            EX2DR: return tms ? UPDR  : SHDR;
            UPDR:  return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPIR  : PAIR;
            PAIR:  return tms ? EX2IR : PAIR;
            EX2IR: return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            tap_st <= TLR;
            tap_ir <= IDC_IR;
        end else begin
            case (tap_st)
                CAPDR: dr_sr <= (tap_ir == IDC_IR) ? IDCODE : 32'b0;
                SHDR:  dr_sr <= (tap_ir == IDC_IR) ? {jtag_tdi, dr_sr[31:1]} : {31'b0, jtag_tdi};
                CAPIR: ir_sr <= 4'b0001;
                SHIR:  ir_sr <= {jtag_tdi, ir_sr[3:1]};
                UPIR:  tap_ir <= ir_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, jtag_tms);
            if (tap_next(tap_st, jtag_tms) == TLR) tap_ir <= IDC_IR;
        end
    end

    always @(negedge jtag_tck)
        tdo_r <= (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

    // Pin log sampled at every tck rising edge.
    int   tck_total = 0;
    logic tms_log [0:8191];
    logic tdi_log [0:8191];
    always @(posedge jtag_tck) begin
        tms_log[tck_total % 8192] <= jtag_tms;
        tdi_log[tck_total % 8192] <= jtag_tdi;
        tck_total <= tck_total + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: scan chain output is capture bits followed by the TDI stream.
    logic       synced_m = 1'b0;
    logic [3:0] ir_m = IDC_IR;

    function automatic logic [31:0] stream(input logic [31:0] cap, input int w,
                                           input logic [31:0] tdi, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = (i < w) ? cap[i] : tdi[i - w];
        return r;
    endfunction

    function automatic logic [3:0] ir_after(input int n, input logic [31:0] tdi);
        logic [3:0] r;
        logic [3:0] cap;
        cap = 4'b0001;
        for (int j = 0; j < 4; j++) r[j] = (n + j < 4) ? cap[n + j] : tdi[n + j - 4];
        return r;
    endfunction

    function automatic logic [63:0] log_vec(input logic which, input int start, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n && k < 64; k++)
            v[k] = which ? tdi_log[(start + k) % 8192] : tms_log[(start + k) % 8192];
        return v;
    endfunction

    logic [31:0] r_data;
    logic        r_err, r_busy1, r_ready_end, r_busy_end;
    int          r_lat, r_ticks, r_trst, r_start;

    // Enter and leave at a negedge; offers the command immediately if cmd_ready is already high.
    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        r_start   = tck_total;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = 6'(len);
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = 6'($urandom);
        cmd_data  = $urandom;
        r_lat = 0;
        r_trst = 0;
        r_busy1 = 1'b0;
        do begin
            @(negedge clk);
            r_lat++;
            if (r_lat == 1) r_busy1 = busy;
            if (!jtag_trst_n) r_trst++;
        end while (!rsp_valid && r_lat < 3000);
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        r_data      = rsp_data;
        r_err       = rsp_err;
        r_ready_end = cmd_ready;
        r_busy_end  = busy;
        r_ticks     = tck_total - r_start;
    endtask

    task automatic exec(input logic [1:0] op, input int len, input logic [31:0] data);
        logic        shift, e_err;
        logic [31:0] e_data;
        int          e_ticks, e_lat, e_trst;
        shift   = (op == 2'b01) || (op == 2'b10);
        e_err   = shift && (len == 0 || len > MLEN || !synced_m);
        e_data  = '0;
        e_ticks = 0;
        e_trst  = 0;
        if (!e_err) begin
            case (op)
                2'b00: begin e_ticks = TRST_T + 6; e_trst = TRST_T * 2 * CDIV; end
                2'b01: begin e_ticks = len + 6; e_data = stream(32'h1, 4, data, len); end
                2'b10: begin
                    e_ticks = len + 5;
                    e_data = (ir_m == IDC_IR) ? stream(IDCODE, 32, data, len) : stream(0, 1, data, len);
                end
                default: e_ticks = len;
            endcase
        end
        e_lat = (e_ticks == 0) ? 1 : 2 * CDIV * e_ticks + 1;
        run_cmd(op, len, data);
        chk("rsp_err", r_err, e_err);
        chk("rsp_data", r_data, e_data);
        chk("tck_ticks", r_ticks, e_ticks);
        chk("latency", r_lat, e_lat);
        chk("trst_low_clks", r_trst, e_trst);
        chk("busy_first", r_busy1, e_ticks != 0);
        chk("ready_at_rsp", r_ready_end, 1);
        chk("busy_at_rsp", r_busy_end, 0);
        if (!e_err && op == 2'b00) begin synced_m = 1'b1; ir_m = IDC_IR; end
        if (!e_err && op == 2'b01) ir_m = ir_after(len, data);
        if (synced_m) chk("tap_in_rti", tap_st, RTI);
    endtask

    initial begin
        int g, st, rsp_seen, tck_seen;
        logic [1:0] op;
        int len;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_tck", jtag_tck, 0);
        chk("rst_tms", jtag_tms, 1);
        chk("rst_trst", jtag_trst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_ready", cmd_ready, 1);
        chk("rel_trst", jtag_trst_n, 1);
        chk("rel_tms", jtag_tms, 1);

        exec(2'b10, 8, 32'hA5);
        exec(2'b00, 0, 32'h0);
        chk("reset_tms_seq", log_vec(1'b0, r_start, r_ticks), (TRST_T != 0) ? 64'h7F : 64'h1F);
        exec(2'b10, 0, 32'h0);
        exec(2'b10, 33, 32'hFFFF_FFFF);
        exec(2'b01, 4, 32'hE);
        chk("ir_tms_seq", log_vec(1'b0, r_start, r_ticks), 64'b01_1000_0011);
        chk("ir_tdi_seq", log_vec(1'b1, r_start, r_ticks), 64'b00_1110_0000);
        exec(2'b10, 32, 32'h0);
        repeat (5) @(negedge clk);
        chk("rsp_hold", {rsp_err, rsp_data}, {1'b0, IDCODE});
        exec(2'b11, 0, 32'h0);
        exec(2'b11, 3, 32'h0);

        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            d   = $urandom;
            len = (op == 2'b11) ? $urandom_range(0, 12) : $urandom_range(0, 36);
            if (op == 2'b01 && $urandom_range(0, 1) == 1) begin
                len = 4;
                d[3:0] = IDC_IR;
            end
            if (op == 2'b00 && $urandom_range(0, 3) != 0) op = 2'b10;
            exec(op, len, d);
        end

        // Reset in the middle of a DR scan.
        exec(2'b00, 0, 32'h0);
        exec(2'b01, 4, 32'hE);
        st = tck_total;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_len = 6'd32;
        cmd_data = $urandom;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        g = 0;
        while ((tck_total - st) < 13 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("mid_wait_done", (tck_total - st) >= 13, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tck", jtag_tck, 0);
        chk("mid_rst_tms", jtag_tms, 1);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        synced_m = 1'b0;
        ir_m = IDC_IR;
        rsp_seen = 0;
        tck_seen = tck_total;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("mid_no_rsp", rsp_seen, 0);
        chk("mid_no_tck", tck_total - tck_seen, 0);
        exec(2'b10, 32, 32'h0);
        exec(2'b00, 0, 32'h0);
        exec(2'b01, 4, 32'hE);
        exec(2'b10, 32, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", n_checks);
        $fatal(1, "timeout");
    end

endmodule
